// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - command encodings, FSM states, word counts and word selects for the stack sequencer
// Contents: cmd_e, state_e, wsel_e, per-command word counts, helper functions
//   word_count : number of stack words a command moves
//   is_push_cmd / is_pop_cmd : command direction
//   word_sel   : which word (reg, PC high, PC low, flags) sits at index idx of a command
package stack_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'b000,
    CMD_PUSH = 3'b001,
    CMD_POP  = 3'b010,
    CMD_CALL = 3'b011,
    CMD_RET  = 3'b100,
    CMD_INT  = 3'b101,
    CMD_RTI  = 3'b110,
    CMD_RSVD = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH  = 2'd1,
    ST_POP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WS_REG   = 2'd0,
    WS_PC_HI = 2'd1,
    WS_PC_LO = 2'd2,
    WS_FLAGS = 2'd3
  } wsel_e;

  localparam logic [1:0] N_PUSH = 2'd1;
  localparam logic [1:0] N_CALL = 2'd2;
  localparam logic [1:0] N_INT  = 2'd3;
  localparam logic [1:0] N_POP  = 2'd1;
  localparam logic [1:0] N_RET  = 2'd2;
  localparam logic [1:0] N_RTI  = 2'd3;

  function automatic logic [1:0] word_count(input cmd_e c);
    case (c)
      CMD_PUSH: word_count = N_PUSH;
      CMD_CALL: word_count = N_CALL;
      CMD_INT:  word_count = N_INT;
      CMD_POP:  word_count = N_POP;
      CMD_RET:  word_count = N_RET;
      CMD_RTI:  word_count = N_RTI;
      default:  word_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_push_cmd(input cmd_e c);
    is_push_cmd = (c == CMD_PUSH) || (c == CMD_CALL) || (c == CMD_INT);
  endfunction

  function automatic logic is_pop_cmd(input cmd_e c);
    is_pop_cmd = (c == CMD_POP) || (c == CMD_RET) || (c == CMD_RTI);
  endfunction

  // Pop orders are the exact reverse of the matching push orders, so the
  // stack image left by CALL/INT is consumed correctly by RET/RTI.
  function automatic wsel_e word_sel(input cmd_e c, input logic [1:0] idx);
    word_sel = WS_REG;
    case (c)
      CMD_CALL: begin
        if (idx == 2'd0) word_sel = WS_PC_HI;
        else             word_sel = WS_PC_LO;
      end
      CMD_INT: begin
        if (idx == 2'd0)      word_sel = WS_PC_HI;
        else if (idx == 2'd1) word_sel = WS_PC_LO;
        else                  word_sel = WS_FLAGS;
      end
      CMD_RET: begin
        if (idx == 2'd0) word_sel = WS_PC_LO;
        else             word_sel = WS_PC_HI;
      end
      CMD_RTI: begin
        if (idx == 2'd0)      word_sel = WS_FLAGS;
        else if (idx == 2'd1) word_sel = WS_PC_LO;
        else                  word_sel = WS_PC_HI;
      end
      default: word_sel = WS_REG;
    endcase
  endfunction

endpackage

// File: rtl/stack_pop_collector.sv
// rtl/stack_pop_collector.sv - assembles popped stack words into PC, flags and register results
// Ports:
//   clk, reset          : clock, async active-high reset
//   i_cap_en, i_cap_sel : capture i_rdata this cycle into the word slot i_cap_sel
//   i_rdata             : memory read data
//   i_finish            : last word is being captured; publish results next cycle
//   i_ld_pc/flags/reg   : which results the finishing command loads
//   o_pc_out/o_pc_load, o_flags_out/o_flags_load, o_reg_out/o_reg_load : registered results and strobes
module stack_pop_collector
  import stack_seq_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cap_en,
  input  logic [1:0]        i_cap_sel,
  input  logic [15:0]       i_rdata,
  input  logic              i_finish,
  input  logic              i_ld_pc,
  input  logic              i_ld_flags,
  input  logic              i_ld_reg,
  output logic [31:0]       o_pc_out,
  output logic              o_pc_load,
  output logic [FLAG_W-1:0] o_flags_out,
  output logic              o_flags_load,
  output logic [15:0]       o_reg_out,
  output logic              o_reg_load
);

  logic [31:0]       r_pc_stage;
  logic [FLAG_W-1:0] r_flags_stage;
  logic [15:0]       r_reg_stage;
  logic [31:0]       w_pc_nx;
  logic [FLAG_W-1:0] w_flags_nx;
  logic [15:0]       w_reg_nx;

  // Staging view including this cycle's word, so the final (DRAIN) word
  // lands in the published outputs on the same edge it is captured.
  always_comb begin
    w_pc_nx    = r_pc_stage;
    w_flags_nx = r_flags_stage;
    w_reg_nx   = r_reg_stage;
    if (i_cap_en) begin
      case (wsel_e'(i_cap_sel))
        WS_REG:   w_reg_nx          = i_rdata;
        WS_PC_HI: w_pc_nx[31:16]    = i_rdata;
        WS_PC_LO: w_pc_nx[15:0]     = i_rdata;
        WS_FLAGS: w_flags_nx        = i_rdata[FLAG_W-1:0];
        default:  w_reg_nx          = r_reg_stage;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_stage    <= 32'h0;
      r_flags_stage <= '0;
      r_reg_stage   <= 16'h0;
      o_pc_out      <= 32'h0;
      o_flags_out   <= '0;
      o_reg_out     <= 16'h0;
      o_pc_load     <= 1'b0;
      o_flags_load  <= 1'b0;
      o_reg_load    <= 1'b0;
    end else begin
      r_pc_stage    <= w_pc_nx;
      r_flags_stage <= w_flags_nx;
      r_reg_stage   <= w_reg_nx;
      o_pc_load     <= i_finish && i_ld_pc;
      o_flags_load  <= i_finish && i_ld_flags;
      o_reg_load    <= i_finish && i_ld_reg;
      if (i_finish && i_ld_pc)    o_pc_out    <= w_pc_nx;
      if (i_finish && i_ld_flags) o_flags_out <= w_flags_nx;
      if (i_finish && i_ld_reg)   o_reg_out   <= w_reg_nx;
    end
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - turns one stack command into a sequence of single-word stack accesses
// Ports:
//   clk, reset                  : clock, async active-high reset
//   cmd_valid, cmd, cmd_ready   : command handshake (ready only in IDLE)
//   pc_in, flags_in, reg_in     : operands latched at accept
//   stack_overflow              : from SP logic, aborts a push sequence
//   mem_rdata                   : read data, valid the cycle after mem_read
//   stack_op, push_pop          : SP update enable / direction (1 = push)
//   mem_write, mem_read, mem_wdata : data-memory strobes and write word
//   stall                       : pipeline hold while busy
//   pc_out/pc_load, flags_out/flags_load, reg_out/reg_load : popped results
//   done, stack_exc             : completion / overflow-abort pulses
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  output logic              cmd_ready,
  input  logic [31:0]       pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [15:0]       reg_in,
  input  logic              stack_overflow,
  input  logic [15:0]       mem_rdata,
  output logic              stack_op,
  output logic              push_pop,
  output logic              mem_write,
  output logic              mem_read,
  output logic [15:0]       mem_wdata,
  output logic              stall,
  output logic [31:0]       pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load,
  output logic [15:0]       reg_out,
  output logic              reg_load,
  output logic              done,
  output logic              stack_exc
);

  state_e            r_state;
  state_e            w_next;
  cmd_e              r_cmd;
  logic [1:0]        r_idx;
  logic [1:0]        r_n;
  logic [31:0]       r_pc;
  logic [FLAG_W-1:0] r_flags;
  logic [15:0]       r_reg;
  logic              r_done;
  logic              r_exc;

  cmd_e              w_cmd;
  logic              w_accept;
  logic              w_last;
  wsel_e             w_sel;
  wsel_e             w_cap_sel;
  logic              w_cap_en;
  logic [15:0]       w_push_word;

  assign w_cmd    = cmd_e'(cmd);
  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_last   = (r_idx == (r_n - 2'd1));
  assign w_sel    = word_sel(r_cmd, r_idx);

  // Read data lags mem_read by a cycle, so the word captured now belongs to
  // index idx-1; in DRAIN idx has already advanced to n.
  assign w_cap_en  = ((r_state == ST_POP) && (r_idx != 2'd0)) || (r_state == ST_DRAIN);
  assign w_cap_sel = word_sel(r_cmd, r_idx - 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && is_push_cmd(w_cmd))     w_next = ST_PUSH;
        else if (w_accept && is_pop_cmd(w_cmd)) w_next = ST_POP;
      end
      ST_PUSH:  if (stack_overflow || w_last) w_next = ST_IDLE;
      ST_POP:   if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (w_sel)
      WS_PC_HI: w_push_word = r_pc[31:16];
      WS_PC_LO: w_push_word = r_pc[15:0];
      WS_FLAGS: w_push_word = 16'(r_flags);
      default:  w_push_word = r_reg;
    endcase
  end

  always_comb begin
    stack_op  = 1'b0;
    push_pop  = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_wdata = 16'h0;
    stall     = (r_state != ST_IDLE);
    cmd_ready = (r_state == ST_IDLE);
    case (r_state)
      ST_PUSH: begin
        stack_op  = 1'b1;
        push_pop  = 1'b1;
        mem_write = ~stack_overflow;
        mem_wdata = w_push_word;
      end
      ST_POP: begin
        stack_op = 1'b1;
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd   <= CMD_NOP;
      r_n     <= 2'd0;
      r_idx   <= 2'd0;
      r_pc    <= 32'h0;
      r_flags <= '0;
      r_reg   <= 16'h0;
      r_done  <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_exc  <= 1'b0;
      if (w_accept) begin
        r_cmd   <= w_cmd;
        r_n     <= word_count(w_cmd);
        r_idx   <= 2'd0;
        r_pc    <= pc_in;
        r_flags <= flags_in;
        r_reg   <= reg_in;
        // NOP and reserved complete without touching the stack
        if (!is_push_cmd(w_cmd) && !is_pop_cmd(w_cmd)) r_done <= 1'b1;
      end else if ((r_state == ST_PUSH) || (r_state == ST_POP)) begin
        r_idx <= r_idx + 2'd1;
      end
      if (r_state == ST_PUSH) begin
        if (stack_overflow) r_exc  <= 1'b1;
        else if (w_last)    r_done <= 1'b1;
      end
      if (r_state == ST_DRAIN) r_done <= 1'b1;
    end
  end

  assign done      = r_done;
  assign stack_exc = r_exc;

  stack_pop_collector #(
    .FLAG_W(FLAG_W)
  ) u_collector (
    .clk          (clk),
    .reset        (reset),
    .i_cap_en     (w_cap_en),
    .i_cap_sel    (w_cap_sel),
    .i_rdata      (mem_rdata),
    .i_finish     (r_state == ST_DRAIN),
    .i_ld_pc      ((r_cmd == CMD_RET) || (r_cmd == CMD_RTI)),
    .i_ld_flags   (r_cmd == CMD_RTI),
    .i_ld_reg     (r_cmd == CMD_POP),
    .o_pc_out     (pc_out),
    .o_pc_load    (pc_load),
    .o_flags_out  (flags_out),
    .o_flags_load (flags_load),
    .o_reg_out    (reg_out),
    .o_reg_load   (reg_load)
  );

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - scoreboard bench for stack_op_sequencer
module tb_stack_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_ready;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic [15:0] reg_in;
  logic        stack_overflow;
  logic [15:0] mem_rdata;
  logic        stack_op, push_pop, mem_write, mem_read;
  logic [15:0] mem_wdata;
  logic        stall;
  logic [31:0] pc_out;
  logic        pc_load;
  logic [3:0]  flags_out;
  logic        flags_load;
  logic [15:0] reg_out;
  logic        reg_load;
  logic        done, stack_exc;

  always #5 clk = ~clk;

  stack_op_sequencer #(.FLAG_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .pc_in(pc_in), .flags_in(flags_in), .reg_in(reg_in), .stack_overflow(stack_overflow),
    .mem_rdata(mem_rdata), .stack_op(stack_op), .push_pop(push_pop), .mem_write(mem_write),
    .mem_read(mem_read), .mem_wdata(mem_wdata), .stall(stall), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load), .reg_out(reg_out), .reg_load(reg_load),
    .done(done), .stack_exc(stack_exc)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] wd;
    logic        dn;
    logic        ex;
    logic        pl;
    logic        fl;
    logic        rl;
    logic [31:0] pc;
    logic [3:0]  fo;
    logic [15:0] ro;
  } ev_t;

  ev_t exp_q[$];
  ev_t m_act, m_exp;
  int  checks = 0;
  int  failures = 0;

  // Stack-pointer and memory model: push pre-decrements, pop post-increments,
  // read data is registered (valid the cycle after mem_read).
  logic [15:0] mem [0:255];
  int          sp = 64;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem_rdata = 16'h0;
  end

  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem[sp[7:0]];
      sp        <= sp + 1;
    end else if (stack_op && push_pop && !stack_overflow) begin
      if (mem_write) mem[(sp - 1) & 255] <= mem_wdata;
      sp <= sp - 1;
    end
  end

  function automatic ev_t mk(logic wr, logic [15:0] wd, logic dn, logic ex, logic pl, logic fl,
                             logic rl, logic [31:0] pc, logic [3:0] fo, logic [15:0] ro);
    ev_t e;
    e.wr = wr; e.wd = wd; e.dn = dn; e.ex = ex; e.pl = pl; e.fl = fl; e.rl = rl;
    e.pc = pc; e.fo = fo; e.ro = ro;
    return e;
  endfunction

  task automatic exp_wr(input logic [15:0] wd);
    exp_q.push_back(mk(1'b1, wd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 16'h0));
  endtask

  task automatic exp_done();
    exp_q.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 16'h0));
  endtask

  task automatic exp_exc();
    exp_q.push_back(mk(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 16'h0));
  endtask

  task automatic exp_load(input logic pl, input logic fl, input logic rl,
                          input logic [31:0] pc, input logic [3:0] fo, input logic [15:0] ro);
    exp_q.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, pl, fl, rl, pc, fo, ro));
  endtask

  // Monitor: any write, done, exception or load is an event checked against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write || mem_read) begin
        checks++;
        if (mem_write && mem_read) begin
          failures++;
          $display("FAIL rw_exclusive actual=both_high required=one_high");
        end
      end
      if (mem_write || done || stack_exc || pc_load || flags_load || reg_load) begin
        m_act = mk(mem_write, mem_write ? mem_wdata : 16'h0, done, stack_exc, pc_load, flags_load,
                   reg_load, pc_load ? pc_out : 32'h0, flags_load ? flags_out : 4'h0,
                   reg_load ? reg_out : 16'h0);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual=%h required=none", m_act);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_act !== m_exp) begin
            failures++;
            $display("FAIL event actual=%h required=%h", m_act, m_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Present a command and wait (bounded) for acceptance; returns with
  // cmd_valid dropped 1 time unit after the accept edge.
  task automatic issue(input logic [2:0] c, input logic [31:0] pc, input logic [3:0] fl,
                       input logic [15:0] rg, output logic done_at_accept);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; pc_in = pc; flags_in = fl; reg_in = rg;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end
    done_at_accept = done;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd = 3'b000;
  endtask

  // Cycles after the accept edge until the chosen strobe: 0 done, 1 pc_load, 2 reg_load.
  task automatic latency(input int which, output int cyc);
    cyc = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if ((which == 0 && done) || (which == 1 && pc_load) || (which == 2 && reg_load)) begin
        cyc = k;
        break;
      end
    end
  endtask

  logic dacc;
  int   lat;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 3'b000; pc_in = 32'h0; flags_in = 4'h0;
    reg_in = 16'h0; stack_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_stack_op", 32'(stack_op), 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // CALL 0x1234ABCD
    exp_wr(16'h1234); exp_wr(16'hABCD); exp_done();
    issue(3'b011, 32'h1234ABCD, 4'h0, 16'h0, dacc);
    @(negedge clk);
    chk("call_c1_stall", 32'(stall), 32'd1);
    chk("call_c1_push_pop", 32'(push_pop), 32'd1);
    chk("call_c1_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("call_c2_stall", 32'(stall), 32'd1);
    chk("call_c2_push_pop", 32'(push_pop), 32'd1);
    @(negedge clk);
    chk("call_c3_done", 32'(done), 32'd1);
    chk("call_c3_ready", 32'(cmd_ready), 32'd1);

    // RET: memory returns 0xABCD then 0x1234
    exp_load(1'b1, 1'b0, 1'b0, 32'h1234ABCD, 4'h0, 16'h0);
    issue(3'b100, 32'h0, 4'h0, 16'h0, dacc);
    latency(1, lat);
    chk("ret_latency", lat, 32'd4);

    // INT then RTI
    exp_wr(16'h1234); exp_wr(16'hABCD); exp_wr(16'h000A); exp_done();
    issue(3'b101, 32'h1234ABCD, 4'hA, 16'h0, dacc);
    latency(0, lat);
    chk("int_latency", lat, 32'd4);
    exp_load(1'b1, 1'b1, 1'b0, 32'h1234ABCD, 4'hA, 16'h0);
    issue(3'b110, 32'h0, 4'h0, 16'h0, dacc);
    latency(1, lat);
    chk("rti_latency", lat, 32'd5);

    // Overflow on the 2nd CALL word
    exp_wr(16'h55AA); exp_exc();
    issue(3'b011, 32'h55AA0F0F, 4'h0, 16'h0, dacc);
    @(negedge clk);
    @(posedge clk); #1; stack_overflow = 1'b1;
    @(negedge clk);
    chk("ovf_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1; stack_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_idle", 32'(stall), 32'd0);
    chk("ovf_exc", 32'(stack_exc), 32'd1);
    chk("ovf_no_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);

    // Reset in the 2nd RTI pop cycle
    issue(3'b110, 32'h0, 4'h0, 16'h0, dacc);
    @(negedge clk);
    @(posedge clk); #1; reset = 1'b1; #1;
    chk("mrst_stack_op", 32'(stack_op), 32'd0);
    chk("mrst_mem_read", 32'(mem_read), 32'd0);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_pc_out", pc_out, 32'h0);
    chk("mrst_flags_out", 32'(flags_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Back-to-back PUSH 0x0005 then POP
    exp_wr(16'h0005); exp_done();
    exp_load(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 16'h0005);
    issue(3'b001, 32'h0, 4'h0, 16'h0005, dacc);
    issue(3'b010, 32'h0, 4'h0, 16'h0, dacc);
    chk("pop_in_done_cycle", 32'(dacc), 32'd1);
    latency(2, lat);
    chk("pop_latency", lat, 32'd3);

    // NOP and reserved
    exp_done();
    issue(3'b000, 32'h0, 4'h0, 16'h0, dacc);
    latency(0, lat);
    chk("nop_latency", lat, 32'd1);
    exp_done();
    issue(3'b111, 32'h0, 4'h0, 16'h0, dacc);
    latency(0, lat);
    chk("rsvd_latency", lat, 32'd1);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
